// File: rtl/oam_dma_ctl.sv
// Sprite-DMA bus master for the 2A03 CPU bus: stalls the core on a trigger write,
// then copies one 256-byte page to the PPU OAM data port as GET/PUT pairs.
module oam_dma_ctl #(
  parameter logic [15:0] P_TRIG_ADDR = 16'h4014,
  parameter logic [15:0] P_DEST_ADDR = 16'h2004
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_step,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  output logic        O_cpu_ready,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] page_r, page_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] data_r, data_s;
  logic       parity_r;
  logic       trig_s;

  assign trig_s = (I_cpu_addr == P_TRIG_ADDR) && (I_cpu_rdwr == 1'b0);

  // Next-state and datapath updates; everything holds on clocks without I_step.
  always_comb begin
    state_s = state_r;
    page_s  = page_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    if (I_step) begin
      case (state_r)
        ST_IDLE: begin
          if (trig_s) begin
            page_s  = I_cpu_wr_data;
            cnt_s   = 8'h00;
            state_s = ST_HALT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HALT: begin
          // Halt on the first CPU read; a PUT halt cycle means the next one is a GET.
          if (I_cpu_rdwr) begin
            if (parity_r) begin
              state_s = ST_READ;
            end else begin
              state_s = ST_ALIGN;
            end
          end else begin
            state_s = ST_HALT;
          end
        end
        ST_ALIGN: begin
          state_s = ST_READ;
        end
        ST_READ: begin
          data_s  = I_rd_data;
          state_s = ST_WRITE;
        end
        ST_WRITE: begin
          cnt_s = cnt_r + 8'h01;
          if (cnt_r == 8'hFF) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_READ;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Bus mux and core ready, combinational so an async reset restores passthrough at once.
  always_comb begin
    O_addr      = I_cpu_addr;
    O_wr_data   = I_cpu_wr_data;
    O_rdwr      = I_cpu_rdwr;
    O_cpu_ready = 1'b1;
    O_busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        O_busy = 1'b0;
      end
      ST_HALT: begin
        O_cpu_ready = ~I_cpu_rdwr;
      end
      ST_ALIGN: begin
        O_cpu_ready = 1'b0;
      end
      ST_READ: begin
        O_addr      = {page_r, cnt_r};
        O_rdwr      = 1'b1;
        O_cpu_ready = 1'b0;
      end
      ST_WRITE: begin
        O_addr      = P_DEST_ADDR;
        O_wr_data   = data_r;
        O_rdwr      = 1'b0;
        O_cpu_ready = 1'b0;
      end
      default: begin
        O_busy = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_r <= ST_IDLE;
      page_r  <= 8'h00;
      cnt_r   <= 8'h00;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      page_r  <= page_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
    end
  end

  // GET/PUT parity runs free across all states.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      parity_r <= 1'b0;
    end else if (I_step) begin
      parity_r <= ~parity_r;
    end else begin
      parity_r <= parity_r;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctl.sv
// Scoreboard bench for oam_dma_ctl: a CPU model honouring ready, a memory model
// answering bus reads, and a queue of expected DMA bus cycles.
module tb_oam_dma_ctl;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic        I_step;
  logic [15:0] I_cpu_addr;
  logic [7:0]  I_cpu_wr_data;
  logic        I_cpu_rdwr;
  logic        O_cpu_ready;
  logic [7:0]  I_rd_data;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;
  logic        O_busy;

  oam_dma_ctl dut (
    .I_clock       (I_clock),
    .I_reset       (I_reset),
    .I_step        (I_step),
    .I_cpu_addr    (I_cpu_addr),
    .I_cpu_wr_data (I_cpu_wr_data),
    .I_cpu_rdwr    (I_cpu_rdwr),
    .O_cpu_ready   (O_cpu_ready),
    .I_rd_data     (I_rd_data),
    .O_addr        (O_addr),
    .O_wr_data     (O_wr_data),
    .O_rdwr        (O_rdwr),
    .O_busy        (O_busy)
  );

  always #5 I_clock = ~I_clock;

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  data;
  } xfer_t;

  logic [7:0] mem [0:65535];
  xfer_t      exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         stall_cnt;
  int         nodma_stall;
  int         writes_seen;
  int         last_tries;
  logic       last_ready;
  logic       par_m;
  logic       halt_par;

  assign I_rd_data = mem[O_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_copy(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, 8'(i)};
      exp_q.push_back('{addr: a, rdwr: 1'b1, data: 8'h00});
      exp_q.push_back('{addr: 16'h2004, rdwr: 1'b0, data: mem[a]});
    end
  endtask

  // One CPU bus cycle: step strobe, sample mid-clock, then an idle clock with no step.
  task automatic step_cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
    logic  dma;
    xfer_t e;
    I_cpu_addr    = a;
    I_cpu_rdwr    = r;
    I_cpu_wr_data = d;
    I_step        = 1'b1;
    @(negedge I_clock);
    dma = (O_addr !== I_cpu_addr) || (O_rdwr !== I_cpu_rdwr);
    if (dma) begin
      if (exp_q.size() == 0) begin
        check_val("dma_unexp_addr", 32'(O_addr), 32'(I_cpu_addr));
      end else begin
        e = exp_q.pop_front();
        check_val("dma_addr", 32'(O_addr), 32'(e.addr));
        check_val("dma_rdwr", 32'(O_rdwr), 32'(e.rdwr));
        check_val("dma_ready", 32'(O_cpu_ready), 32'd0);
        if (!e.rdwr) begin
          check_val("dma_data", 32'(O_wr_data), 32'(e.data));
          writes_seen++;
        end
      end
    end
    if (!O_cpu_ready) begin
      stall_cnt++;
      if (!dma) nodma_stall++;
    end
    last_ready = O_cpu_ready;
    @(posedge I_clock);
    #1;
    I_step = 1'b0;
    par_m  = ~par_m;
    @(posedge I_clock);
    #1;
  endtask

  // CPU access that repeats while the core is stalled.
  task automatic cpu_access(input logic [15:0] a, input logic r, input logic [7:0] d);
    if (a == 16'h4014 && r == 1'b0) push_copy(d);
    halt_par   = par_m;
    last_tries = 0;
    do begin
      step_cycle(a, r, d);
      last_tries++;
    end while (!last_ready && last_tries < 1000);
    if (!last_ready) check_val("cpu_hang", 32'(last_ready), 32'd1);
  endtask

  // Trigger plus halting read, aligned so the halt read lands on parity want_put.
  task automatic run_copy(input logic [7:0] page, input logic want_put);
    if ((par_m ^ 1'b1) != want_put) step_cycle(16'h8100, 1'b1, 8'h00);
    stall_cnt   = 0;
    nodma_stall = 0;
    cpu_access(16'h4014, 1'b0, page);
    check_val("trig_tries", 32'(last_tries), 32'd1);
    check_val("busy_halt", 32'(O_busy), 32'd1);
    cpu_access(16'h8000, 1'b1, 8'h00);
    check_val("halt_par", 32'(halt_par), 32'(want_put));
    check_val("stall_len", 32'(stall_cnt), want_put ? 32'd513 : 32'd514);
    check_val("stall_nodma", 32'(nodma_stall), want_put ? 32'd1 : 32'd2);
    check_val("q_empty", 32'(exp_q.size()), 32'd0);
    check_val("busy_end", 32'(O_busy), 32'd0);
    check_val("reread_addr", 32'(O_addr), 32'h8000);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0300 + i] = 8'(255 - i);
    end
    I_reset = 1'b0; I_step = 1'b0;
    I_cpu_addr = 16'h0000; I_cpu_wr_data = 8'h00; I_cpu_rdwr = 1'b1;
    par_m = 1'b0; writes_seen = 0; stall_cnt = 0; nodma_stall = 0;

    // Reset with random inputs, including trigger writes.
    for (int i = 0; i < 6; i++) begin
      @(posedge I_clock);
      #1;
      I_cpu_addr    = (i % 2 == 0) ? 16'h4014 : 16'($urandom);
      I_cpu_rdwr    = 1'($urandom);
      I_cpu_wr_data = 8'($urandom);
      I_step        = 1'($urandom);
      #1;
      check_val("rst_ready", 32'(O_cpu_ready), 32'd1);
      check_val("rst_busy", 32'(O_busy), 32'd0);
      check_val("rst_addr", 32'(O_addr), 32'(I_cpu_addr));
      check_val("rst_rdwr", 32'(O_rdwr), 32'(I_cpu_rdwr));
    end
    @(posedge I_clock);
    #1;
    I_step = 1'b0;
    I_reset = 1'b1;
    par_m = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_cycle(16'h8000 + 16'($urandom_range(0, 255)), 1'b1, 8'h00);
      check_val("post_rst_busy", 32'(O_busy), 32'd0);
    end

    // Basic copy with halt on a PUT cycle, then with alignment.
    run_copy(8'h02, 1'b1);
    run_copy(8'h02, 1'b0);

    // Writes after the trigger pass through; the halt is the following read.
    stall_cnt = 0; nodma_stall = 0;
    cpu_access(16'h4014, 1'b0, 8'h02);
    cpu_access(16'h01FD, 1'b0, 8'hC0);
    check_val("push1_tries", 32'(last_tries), 32'd1);
    check_val("push1_addr", 32'(O_addr), 32'h01FD);
    check_val("push1_data", 32'(O_wr_data), 32'hC0);
    check_val("push1_busy", 32'(O_busy), 32'd1);
    cpu_access(16'h01FC, 1'b0, 8'h12);
    check_val("push2_tries", 32'(last_tries), 32'd1);
    check_val("push2_ready", 32'(O_cpu_ready), 32'd1);
    check_val("push_stall", 32'(stall_cnt), 32'd0);
    cpu_access(16'h8000, 1'b1, 8'h00);
    check_val("push_halt_len", 32'(stall_cnt), halt_par ? 32'd513 : 32'd514);
    check_val("push_q_empty", 32'(exp_q.size()), 32'd0);

    // Page FF with no carry, then a back-to-back trigger for page 03.
    run_copy(8'hFF, 1'b1);
    run_copy(8'h03, par_m ^ 1'b1);

    // Abort by reset after 100 bytes.
    if (par_m != 1'b0) step_cycle(16'h8100, 1'b1, 8'h00);
    cpu_access(16'h4014, 1'b0, 8'h02);
    writes_seen = 0;
    for (int i = 0; i < 1000 && writes_seen < 100; i++) step_cycle(16'h8000, 1'b1, 8'h00);
    check_val("abort_writes", 32'(writes_seen), 32'd100);
    check_val("abort_busy_pre", 32'(O_busy), 32'd1);
    I_reset = 1'b0;
    #1;
    check_val("abort_ready", 32'(O_cpu_ready), 32'd1);
    check_val("abort_busy", 32'(O_busy), 32'd0);
    check_val("abort_addr", 32'(O_addr), 32'h8000);
    check_val("abort_rdwr", 32'(O_rdwr), 32'd1);
    exp_q.delete();
    @(posedge I_clock);
    #1;
    I_reset = 1'b1;
    par_m = 1'b0;
    writes_seen = 0;
    for (int i = 0; i < 10; i++) step_cycle(16'h8000, 1'b1, 8'h00);
    check_val("abort_no_writes", 32'(writes_seen), 32'd0);
    check_val("abort_idle", 32'(O_busy), 32'd0);

    p = 8'h00;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + int'(p));
    $finish;
  end

endmodule
